// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register: advances, inserts a bubble or holds according to the global stall vector.
// It also returns multi-cycle scratch state upstream and keeps saturating perf counters and a protocol error flag.
module pipe_stage_reg #(
  parameter int STALL_W   = 6,
  parameter int STAGE     = 3,
  parameter int PAYLOAD_W = 64,
  parameter int WEN_W     = 2,
  parameter int SCRATCH_W = 64,
  parameter int CNT_W     = 2,
  parameter int PERF_W    = 16,
  parameter logic [PAYLOAD_W-1:0] RESET_PAYLOAD = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [WEN_W-1:0]     in_wen,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [SCRATCH_W-1:0] scratch_i,
  input  logic [CNT_W-1:0]     cnt_i,
  input  logic                 perf_clr,
  output logic                 out_valid,
  output logic [WEN_W-1:0]     out_wen,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [SCRATCH_W-1:0] scratch_o,
  output logic [CNT_W-1:0]     cnt_o,
  output logic [PERF_W-1:0]    bubble_cnt,
  output logic [PERF_W-1:0]    hold_cnt,
  output logic                 proto_err
);

  typedef enum logic [1:0] {
    MODE_ADVANCE,
    MODE_BUBBLE,
    MODE_HOLD,
    MODE_ILLEGAL
  } mode_t;

  mode_t mode;
  logic  up;
  logic  dn;

  assign up = stall[STAGE];
  assign dn = stall[STAGE+1];

  always_comb begin
    mode = MODE_ADVANCE;
    case ({up, dn})
      2'b00:   mode = MODE_ADVANCE;
      2'b01:   mode = MODE_ILLEGAL;
      2'b10:   mode = MODE_BUBBLE;
      default: mode = MODE_HOLD;
    endcase
  end

  // Pipeline contents and scratch feedback; flush overrides every stall pattern.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid   <= 1'b0;
      out_wen     <= '0;
      out_payload <= RESET_PAYLOAD;
      scratch_o   <= '0;
      cnt_o       <= '0;
    end else begin
      case (mode)
        MODE_ADVANCE, MODE_ILLEGAL: begin
          out_valid   <= in_valid;
          out_wen     <= in_wen;
          out_payload <= in_payload;
          scratch_o   <= '0;
          cnt_o       <= '0;
        end
        MODE_BUBBLE: begin
          out_valid   <= 1'b0;
          out_wen     <= '0;
          out_payload <= RESET_PAYLOAD;
          scratch_o   <= scratch_i;
          cnt_o       <= cnt_i;
        end
        default: begin
          scratch_o   <= scratch_i;
          cnt_o       <= cnt_i;
        end
      endcase
    end
  end

  // Perf counters and sticky error; a same-cycle clear beats any increment.
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      bubble_cnt <= '0;
      hold_cnt   <= '0;
      proto_err  <= 1'b0;
    end else if (!flush) begin
      if (mode == MODE_BUBBLE && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + 1'b1;
      if (mode == MODE_HOLD && hold_cnt != '1)
        hold_cnt <= hold_cnt + 1'b1;
      if (mode == MODE_ILLEGAL)
        proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed steps followed by random traffic,
// compared against a behavioural model of the stage.
module tb_pipe_stage_reg;

  localparam int MAXC = 65535;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        in_valid;
  logic [1:0]  in_wen;
  logic [63:0] in_payload;
  logic [63:0] scratch_i;
  logic [1:0]  cnt_i;
  logic        perf_clr;
  logic        out_valid;
  logic [1:0]  out_wen;
  logic [63:0] out_payload;
  logic [63:0] scratch_o;
  logic [1:0]  cnt_o;
  logic [15:0] bubble_cnt;
  logic [15:0] hold_cnt;
  logic        proto_err;

  int errors = 0;
  int checks = 0;

  logic        m_valid;
  logic [1:0]  m_wen;
  logic [63:0] m_payload;
  logic [63:0] m_scratch;
  logic [1:0]  m_cnt;
  int          m_bubble;
  int          m_hold;
  logic        m_err;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_wen(in_wen), .in_payload(in_payload),
    .scratch_i(scratch_i), .cnt_i(cnt_i), .perf_clr(perf_clr),
    .out_valid(out_valid), .out_wen(out_wen), .out_payload(out_payload),
    .scratch_o(scratch_o), .cnt_o(cnt_o),
    .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // What one clock edge should do, stated directly from the stage's rules.
  task automatic stepModel();
    bit up, dn;
    up = stall[3];
    dn = stall[4];
    if (rst) begin
      m_valid = 0; m_wen = 0; m_payload = 0; m_scratch = 0; m_cnt = 0;
      m_bubble = 0; m_hold = 0; m_err = 0;
    end else begin
      if (flush) begin
        m_valid = 0; m_wen = 0; m_payload = 0; m_scratch = 0; m_cnt = 0;
      end else if (!up) begin
        m_valid = in_valid; m_wen = in_wen; m_payload = in_payload;
        m_scratch = 0; m_cnt = 0;
        if (dn) m_err = 1;
      end else begin
        m_scratch = scratch_i; m_cnt = cnt_i;
        if (!dn) begin
          m_valid = 0; m_wen = 0; m_payload = 0;
          if (m_bubble < MAXC) m_bubble++;
        end else if (m_hold < MAXC) begin
          m_hold++;
        end
      end
      if (perf_clr) begin
        m_bubble = 0; m_hold = 0; m_err = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [5:0] s, input logic f,
                               input logic v, input logic [1:0] w, input logic [63:0] p,
                               input logic [63:0] sc, input logic [1:0] c, input logic pc);
    rst = r; stall = s; flush = f; in_valid = v; in_wen = w; in_payload = p;
    scratch_i = sc; cnt_i = c; perf_clr = pc;
    @(posedge clk);
    stepModel();
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".valid"},   64'(out_valid),   64'(m_valid));
    checkValue({tag, ".wen"},     64'(out_wen),     64'(m_wen));
    checkValue({tag, ".payload"}, out_payload,      m_payload);
    checkValue({tag, ".scratch"}, scratch_o,        m_scratch);
    checkValue({tag, ".cnt"},     64'(cnt_o),       64'(m_cnt));
    checkValue({tag, ".bubble"},  64'(bubble_cnt),  64'(m_bubble));
    checkValue({tag, ".hold"},    64'(hold_cnt),    64'(m_hold));
    checkValue({tag, ".err"},     64'(proto_err),   64'(m_err));
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0; in_valid = 0; in_wen = 0; in_payload = 0;
    scratch_i = 0; cnt_i = 0; perf_clr = 0;

    applyStimulus(1, 6'b000000, 0, 0, 2'b00, 64'h0, 64'h0, 2'd0, 0);
    applyStimulus(1, 6'b000000, 0, 0, 2'b00, 64'h0, 64'h0, 2'd0, 0);
    checkOutput("reset");
    checkValue("reset.payload_const", out_payload, 64'h0);

    applyStimulus(0, 6'b000000, 0, 1, 2'b11, 64'h1234, 64'h0, 2'd0, 0);
    checkOutput("advance");
    checkValue("advance.payload_const", out_payload, 64'h1234);

    applyStimulus(0, 6'b001000, 0, 1, 2'b11, 64'h9999, 64'hAA, 2'd1, 0);
    checkOutput("bubble");
    checkValue("bubble.scratch_const", scratch_o, 64'hAA);
    checkValue("bubble.count_const", 64'(bubble_cnt), 64'd1);

    applyStimulus(0, 6'b000000, 0, 1, 2'b01, 64'h55, 64'h0, 2'd0, 0);
    checkOutput("load55");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 6'b011000, 0, 0, 2'b10, 64'hDEAD, 64'(i + 16'h100), 2'(i), 0);
      checkOutput("hold");
    end
    checkValue("hold.payload_const", out_payload, 64'h55);
    checkValue("hold.count_const", 64'(hold_cnt), 64'd3);

    applyStimulus(0, 6'b011000, 1, 1, 2'b11, 64'h77, 64'hBEEF, 2'd2, 0);
    checkOutput("flush");
    checkValue("flush.hold_const", 64'(hold_cnt), 64'd3);

    applyStimulus(0, 6'b010000, 0, 1, 2'b10, 64'h4242, 64'h0, 2'd0, 0);
    checkOutput("illegal");
    checkValue("illegal.err_const", 64'(proto_err), 64'd1);

    for (int i = 0; i < MAXC + 6; i++)
      applyStimulus(0, 6'b001000, 0, 1, 2'b11, 64'h1, 64'h5, 2'd3, 0);
    checkOutput("saturate");
    checkValue("saturate.count_const", 64'(bubble_cnt), 64'hFFFF);

    applyStimulus(0, 6'b001000, 0, 0, 2'b00, 64'h0, 64'h6, 2'd1, 1);
    checkOutput("clear");
    checkValue("clear.bubble_const", 64'(bubble_cnt), 64'd0);
    checkValue("clear.err_const", 64'(proto_err), 64'd0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0), 6'($urandom), ($urandom_range(0, 15) == 0),
                    1'($urandom), 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                    2'($urandom), ($urandom_range(0, 31) == 0));
      checkOutput("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
